// File: rtl/dmem_bank_if.sv
// dmem_bank_if: request/response handshake bundle between the MEM stage and dmem_bank
interface dmem_bank_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport slave (
        input  req_valid, req_we, req_addr, req_type, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport master (
        output req_valid, req_we, req_addr, req_type, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// dmem_bank: byte/half/word load-store bank with configurable read latency; DMEM_MISALIGN_CHK_EN adds misalignment faults
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS),
    parameter int READ_LAT    = 1
) (
    input logic        clk,
    input logic        rst,
    dmem_bank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    state_e            state_q;
    logic [1:0]        cnt_q;
    logic [31:0]       word_q;
    logic [1:0]        off_q;
    logic [2:0]        type_q;
    logic              err_q;
    logic              we_q;
    logic [31:0]       ram [DEPTH_WORDS];
    logic              accept;
    logic              mis;
    logic              fault;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       ext;
    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign idx           = bus.req_addr[IDX_W+1:2];
`ifdef DMEM_MISALIGN_CHK_EN
    assign mis = (bus.req_type[1:0] == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_type[1] && bus.req_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign fault = ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS)) || mis;
    assign be    = bus.req_type[1:0] == 2'b00 ? 4'b0001 << bus.req_addr[1:0] :
                   bus.req_type[1:0] == 2'b01 ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wlane = bus.req_type[1:0] == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                   bus.req_type[1:0] == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !fault)
            for (int b = 0; b < 4; b++)
                if (be[b]) ram[idx][8*b +: 8] <= wlane[8*b +: 8];
    end
    // WAIT only counts; the captured word is held unchanged until the response retires
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            off_q   <= '0;
            type_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    word_q  <= ram[idx];
                    off_q   <= bus.req_addr[1:0];
                    type_q  <= bus.req_type;
                    we_q    <= bus.req_we;
                    err_q   <= fault;
                    cnt_q   <= 2'(READ_LAT > 1);
                    state_q <= (READ_LAT == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'(READ_LAT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= RESP;
                    end
                end
                RESP: if (bus.rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign byte_v = word_q[{off_q, 3'b000} +: 8];
    assign half_v = off_q[1] ? word_q[31:16] : word_q[15:0];
    assign ext    = type_q[1:0] == 2'b00 ? {{24{~type_q[2] & byte_v[7]}}, byte_v} :
                    type_q[1:0] == 2'b01 ? {{16{~type_q[2] & half_v[15]}}, half_v} : word_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = (err_q || we_q) ? '0 : ext;
endmodule

// File: tb/tb_dmem_bank.sv
// tb_dmem_bank: randomized check of two dmem_bank instances (READ_LAT 1 and 3) against a byte-level memory model
module tb_dmem_bank;
    localparam int DEPTH = 1024;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        we;
    logic        rsp_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  typ;
    int          sel;
    logic        rdy;
    logic        vld;
    logic        err;
    logic [31:0] rdata;
    int          n_tests = 0;
    int          n_fail = 0;
    int          lat [2] = '{1, 3};
    logic [7:0]  mb [2][4096];
    logic [31:0] got;
    dmem_bank_if b1 ();
    dmem_bank_if b3 ();
    dmem_bank #(.DEPTH_WORDS(DEPTH), .READ_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_bank #(.DEPTH_WORDS(DEPTH), .READ_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
    assign b1.req_valid = valid && sel == 0;
    assign b3.req_valid = valid && sel == 1;
    assign b1.req_we    = we;
    assign b3.req_we    = we;
    assign b1.req_addr  = addr;
    assign b3.req_addr  = addr;
    assign b1.req_type  = typ;
    assign b3.req_type  = typ;
    assign b1.req_wdata = wdata;
    assign b3.req_wdata = wdata;
    assign b1.rsp_ready = rsp_ready;
    assign b3.rsp_ready = rsp_ready;
    assign rdy   = sel == 0 ? b1.req_ready : b3.req_ready;
    assign vld   = sel == 0 ? b1.rsp_valid : b3.rsp_valid;
    assign err   = sel == 0 ? b1.rsp_err   : b3.rsp_err;
    assign rdata = sel == 0 ? b1.rsp_rdata : b3.rsp_rdata;
    always #5 clk = ~clk;
    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask
    task automatic model(input int d, input logic w, input logic [31:0] a, input logic [2:0] t,
                         input logic [31:0] wd, output logic [31:0] r, output logic e);
        int n, base, wb;
        logic [31:0] v;
        n    = t[1:0] == 2'b00 ? 1 : t[1:0] == 2'b01 ? 2 : 4;
        base = n == 1 ? int'(a % 4) : n == 2 ? int'(a % 4) / 2 * 2 : 0;
        e    = (a >> 2) >= 32'(DEPTH);
`ifdef DMEM_MISALIGN_CHK_EN
        if (a % n != 0) e = 1'b1;
`endif
        r = '0;
        if (e) return;
        wb = int'(a - a % 4);
        if (w) begin
            for (int i = 0; i < n; i++) mb[d][wb + base + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v |= 32'(mb[d][wb + base + i]) << (8 * i);
            if (!t[2] && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
            r = v;
        end
    endtask
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [2:0] t,
                        input logic [31:0] wd, input int hold, output logic [31:0] obs);
        logic [31:0] er;
        logic        ee;
        int          n;
        model(d, w, a, t, wd, er, ee);
        sel = d;
        n = 0;
        while (!rdy && n < 20) begin @(negedge clk); n++; end
        check("req_ready_wait", 32'(rdy), 32'd1);
        valid = 1'b1; we = w; addr = a; typ = t; wdata = wd; rsp_ready = (hold == 0);
        @(posedge clk);
        #1 valid = 1'b0; we = ~w; addr = ~a; typ = ~t; wdata = ~wd;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (vld) break;
            check("busy_ready", 32'(rdy), 32'd0);
        end
        check("latency", 32'(n), 32'(lat[d]));
        check("rdata", rdata, er);
        check("err", 32'(err), 32'(ee));
        obs = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(vld), 32'd1);
            check("hold_rdata", rdata, er);
            check("hold_ready", 32'(rdy), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_valid", 32'(vld), 32'd0);
        check("post_ready", 32'(rdy), 32'd1);
    endtask
    initial begin
        rst = 1'b1; valid = 1'b0; we = 1'b0; rsp_ready = 1'b1;
        addr = '0; typ = '0; wdata = '0; sel = 0;
        repeat (3) @(negedge clk);
        check("rst_ready1", 32'(b1.req_ready), 32'd0);
        check("rst_ready3", 32'(b3.req_ready), 32'd0);
        check("rst_valid1", 32'(b1.rsp_valid), 32'd0);
        check("rst_valid3", 32'(b3.rsp_valid), 32'd0);
        check("rst_rdata1", b1.rsp_rdata, 32'd0);
        check("rst_err3", 32'(b3.rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++) xact(d, 1'b1, 32'(w * 4), 3'b010, $urandom, 0, got);
        xact(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, got);
        xact(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, got);
        check("lw_beef", got, 32'hDEADBEEF);
        xact(0, 1'b1, 32'h10, 3'b010, 32'h11223344, 0, got);
        xact(0, 1'b1, 32'h13, 3'b000, 32'h00000080, 0, got);
        xact(0, 1'b0, 32'h13, 3'b000, 32'h0, 0, got);
        check("lb_signed", got, 32'hFFFFFF80);
        xact(0, 1'b0, 32'h13, 3'b100, 32'h0, 0, got);
        check("lbu", got, 32'h00000080);
        xact(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, got);
        check("lw_after_sb", got, 32'h80223344);
        xact(0, 1'b1, 32'h20, 3'b010, 32'h0, 0, got);
        xact(0, 1'b1, 32'h22, 3'b001, 32'h0000A5A5, 0, got);
        xact(0, 1'b0, 32'h22, 3'b001, 32'h0, 0, got);
        check("lh_signed", got, 32'hFFFFA5A5);
        xact(0, 1'b0, 32'h20, 3'b010, 32'h0, 0, got);
        check("lw_after_sh", got, 32'hA5A50000);
        xact(1, 1'b1, 32'h10, 3'b010, 32'hCAFEF00D, 0, got);
        xact(1, 1'b0, 32'h10, 3'b010, 32'h0, 5, got);
        check("lat3_hold", got, 32'hCAFEF00D);
        xact(0, 1'b1, 32'h0, 3'b010, 32'h01020304, 0, got);
        xact(0, 1'b1, 32'h1000, 3'b010, 32'hFFFFFFFF, 0, got);
        check("range_store_err", 32'(err), 32'd1);
        xact(0, 1'b0, 32'h0, 3'b010, 32'h0, 0, got);
        check("range_word0", got, 32'h01020304);
        xact(0, 1'b0, 32'h02, 3'b010, 32'h0, 0, got);
`ifdef DMEM_MISALIGN_CHK_EN
        check("misalign_rdata", got, 32'h0);
`else
        check("unaligned_word", got, 32'h01020304);
`endif
        xact(0, 1'b1, 32'h40, 3'b010, 32'h55, 0, got);
        sel = 0;
        valid = 1'b1; we = 1'b1; addr = 32'h40; typ = 3'b010; wdata = 32'hBAD; rst = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        check("rst_store_valid", 32'(vld), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_store_ready", 32'(rdy), 32'd1);
        xact(0, 1'b0, 32'h40, 3'b010, 32'h0, 0, got);
        check("rst_store_nowrite", got, 32'h55);
        sel = 1;
        valid = 1'b1; we = 1'b0; addr = 32'h10; typ = 3'b010;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        check("wait_ready", 32'(rdy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait_valid", 32'(vld), 32'd0);
        check("rst_wait_ready", 32'(rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wait_idle", 32'(rdy), 32'd1);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 300; i++)
                xact(d, 1'($urandom % 2), ($urandom % 8 == 0) ? $urandom : $urandom % 4096,
                     3'($urandom % 8), $urandom, int'($urandom % 3), got);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_bank.md
Name: dmem_bank

Overview:
Parametrised data-memory bank for the xgriscv core. It performs byte, halfword and word loads and stores, with sign or zero extension on loads, behind valid/ready request and response handshakes. The read latency is configurable, and out-of-range accesses are detected. It sits between the MEM stage and the backing word-organised RAM, and allows one outstanding access at a time.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2.
IDX_W, $clog2(DEPTH_WORDS), word-index width; addr[IDX_W+1:2] selects the word.
READ_LAT, 1, cycles from request accept to rsp_valid; legal range 1..4.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  request present.
req_ready  out  1  bank can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_type  in  3  [1:0]: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word). [2]: 1 = zero-extend load, 0 = sign-extend load.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer takes the response.
rsp_rdata  out  32  extended load data; 0 for stores and for errors.
rsp_err  out  1  access fault (range error, or misalignment when checking is enabled).

Behaviour:
- Reset values: FSM = IDLE, req_ready = 0 during reset, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid, accept the request and go to WAIT (READ_LAT > 1) or RESP (READ_LAT = 1).
  - WAIT: counter runs from 1 up to READ_LAT-1, then go to RESP.
  - RESP: rsp_valid = 1. Hold rsp_rdata and rsp_err stable until rsp_valid && rsp_ready, then go to IDLE.
  - req_ready = 0 in WAIT and RESP. There is no same-cycle accept on the exit from RESP.
- Latency: request accepted at edge T gives rsp_valid = 1 starting at edge T+READ_LAT.
- Range check: err_range = (req_addr[31:2] >= DEPTH_WORDS). A faulting access does not write, returns rsp_rdata = 0 and rsp_err = 1, with the same latency as a normal access.
- Store (accept edge, no fault): writes ram[addr[IDX_W+1:2]] through byte enables.
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes {1,0} or {3,2} per addr[1] get wdata[15:0].
  - Word: all four lanes get wdata.
  - Other lanes are unchanged. There is no read-modify-write.
  - Response: rsp_rdata = 0, rsp_err = 0.
- Load: the word is read into a register at the accept edge, then delayed READ_LAT-1 stages.
  - Lane select: byte by addr[1:0], half by addr[1].
  - Extension per req_type[2]. Extension is applied on the registered word using registered addr[1:0] and type.
- Hazards: a load following a store to the same word sees the stored data, because accesses are serialised.
- Registered state: all request fields are captured at accept. Input changes after accept have no effect.
- Reset mid-operation: rst has priority over every event. A store presented in the same cycle as rst is not written. A pending response is discarded (rsp_valid = 0 on the next cycle) and the FSM returns to IDLE.
- Address wrap: bits above IDX_W+1 are used only for the range check, never for indexing.

Optional Feature:
Macro DMEM_MISALIGN_CHK_EN.
- Defined: the following faults set rsp_err = 1, with no write and rsp_rdata = 0, at normal latency:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0.
- Undefined: misaligned low bits are ignored. Half uses addr[1] only, word uses the aligned word, and rsp_err reflects range faults only.

Test Plan:
- READ_LAT = 1. Store word 0xDEADBEEF at 0x10, then load word 0x10 -> rsp_valid exactly 1 cycle after accept, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Store byte 0x80 at 0x13 over 0x11223344, then:
  - signed byte load 0x13 -> 0xFFFFFF80;
  - unsigned byte load (type 100) -> 0x00000080;
  - word load -> 0x80223344.
- Store half 0xA5A5 at 0x22 over 0; signed half load 0x22 -> 0xFFFFA5A5; word load 0x20 -> 0xA5A50000.
- READ_LAT = 3, rsp_ready held low 5 cycles:
  - rsp_valid rises at T+3 and data stays stable;
  - req_ready = 0 throughout;
  - request accepted only after the handshake cycle.
- DEPTH_WORDS = 1024: store to 0x1000 -> rsp_err = 1 and word 0 unchanged. With DMEM_MISALIGN_CHK_EN, word load 0x02 -> rsp_err = 1, rsp_rdata = 0.
- Assert rst in the cycle a store is accepted, and separately during WAIT -> no RAM write, rsp_valid = 0 the next cycle, FSM in IDLE (req_ready = 1 after rst drops).
